morse_interval_timer: RTL and testbench
=======================================

# morse_interval_timer

Parametrised key-timing engine for the Morse decoder front end. Measures debounced key-press and key-release intervals in clock cycles and classifies them into dot/dash elements and letter-gap, word-gap and inactivity-timeout events, each emitted as a one-cycle pulse. Generalises the single-timeout wait timer: configurable thresholds and counter width, plus element classification and an element count per letter. Sits between the key debouncer and the letter state machine.

## Interface
- CNT_W, 16: interval counter width; counter saturates at 2^CNT_W-1.
- DOT_MAX, 3: longest press, in cycles, classified as a dot.
- LETTER_GAP, 6: release length, in cycles, that ends a letter.
- WORD_GAP, 14: release length, in cycles, that ends a word.
- TIMEOUT, 30: release length, in cycles, that returns the block to idle.
- Legal only with 1 <= DOT_MAX < LETTER_GAP < WORD_GAP < TIMEOUT <= 2^CNT_W-1.
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Enable  in  1  synchronous enable; 0 forces IDLE and clears all outputs.
- Key  in  1  debounced, Clk-synchronous key level; 1 = pressed.
- Dot  out  1  one-cycle pulse: a press <= DOT_MAX cycles ended.
- Dash  out  1  one-cycle pulse: a press > DOT_MAX cycles ended.
- LetterEnd  out  1  one-cycle pulse: release reached LETTER_GAP.
- WordEnd  out  1  one-cycle pulse: release reached WORD_GAP.
- Timeout  out  1  one-cycle pulse: release reached TIMEOUT.
- ElemCnt  out  3  elements since last LetterEnd/idle, saturates at 7.
- Busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, PRESS, GAP. Registered outputs; reset value of every output and cnt is 0, state IDLE.
- IDLE: Key=1 sampled -> PRESS, cnt<=1, ElemCnt<=0. Key=0: stay.
- PRESS: Key=1 -> cnt<=cnt+1 (saturating). Key=0 -> GAP, cnt<=1; Dot<=1 if cnt<=DOT_MAX else Dash<=1; ElemCnt<=ElemCnt+1 (saturating at 7).
- Press of N cycles therefore has cnt==N at release; N==DOT_MAX is a dot, DOT_MAX+1 is a dash. Saturated counter remains a dash.
- GAP: Key=1 -> PRESS, cnt<=1, no gap pulse (intra-letter gap). Key=0 -> cnt<=cnt+1; when the increment makes cnt==LETTER_GAP: LetterEnd<=1, ElemCnt<=0; cnt==WORD_GAP: WordEnd<=1; cnt==TIMEOUT: Timeout<=1, state<=IDLE, cnt<=0.
- Each gap pulse fires at most once per gap; WordEnd is always preceded by LetterEnd in the same gap.
- Press after LetterEnd but before WORD_GAP starts a new letter in the same word.
- Enable=0 (any state, including mid-press): next edge state IDLE, cnt 0, ElemCnt 0, all pulses 0; no Dot/Dash for the aborted press.
- Reset asserted mid-operation: immediate return to reset values; nothing emitted.

## Timing
- Dot/Dash: high for exactly the cycle after the edge that first samples Key=0 in PRESS.
- LetterEnd: high the cycle after the edge on which the LETTER_GAP-th consecutive Key=0 cycle is sampled (release cycle counts as 1). Same rule for WordEnd/TIMEOUT.
- Busy falls in the same cycle Timeout is high.
- Key re-pressed on the very cycle cnt would reach a threshold: press wins, no gap pulse.
- No two of Dot/Dash/LetterEnd/WordEnd/Timeout are ever high in the same cycle (thresholds strictly ordered).

## Test plan
- Defaults; Key high 3 cycles then low -> Dot pulse 1 cycle after release, ElemCnt=1; Key high 4 cycles -> Dash, ElemCnt=2.
- Dot, then Key low 6 cycles -> LetterEnd once, ElemCnt=0; continue low to 14 -> WordEnd once; to 30 -> Timeout once, Busy=0, state IDLE.
- Dot, Key low 5 cycles, press again -> no LetterEnd; second element gives ElemCnt=2.
- Eight dots separated by 2-cycle gaps -> ElemCnt saturates at 7, eight Dot pulses.
- CNT_W=4, press held 40 cycles -> counter saturates at 15, single Dash on release.
- Assert Enable=0 mid-press, and separately Reset mid-gap -> all outputs 0 next cycle, no Dot/Dash/LetterEnd emitted, Busy=0.

Source files
------------

// File: rtl/morse_interval_timer.sv
// Key-timing engine for the Morse decoder front end: measures press/release
// intervals and emits dot/dash, letter-gap, word-gap and timeout pulses.
module morse_interval_timer #(
    parameter int CNT_W      = 16,
    parameter int DOT_MAX    = 3,
    parameter int LETTER_GAP = 6,
    parameter int WORD_GAP   = 14,
    parameter int TIMEOUT    = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Key,
    output logic       Dot,
    output logic       Dash,
    output logic       LetterEnd,
    output logic       WordEnd,
    output logic       Timeout,
    output logic [2:0] ElemCnt,
    output logic       Busy
);

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DOT_LIM = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] LG_LIM  = CNT_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] WG_LIM  = CNT_W'(WORD_GAP);
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [2:0] elem_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    assign cnt_next = cnt_inc(cnt);
    assign Busy     = (state != IDLE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ElemCnt   <= 3'd0;
            Dot       <= 1'b0;
            Dash      <= 1'b0;
            LetterEnd <= 1'b0;
            WordEnd   <= 1'b0;
            Timeout   <= 1'b0;
        end else begin
            Dot       <= 1'b0;
            Dash      <= 1'b0;
            LetterEnd <= 1'b0;
            WordEnd   <= 1'b0;
            Timeout   <= 1'b0;
            if (!Enable) begin
                // Aborting drops any press in flight without classifying it
                state   <= IDLE;
                cnt     <= '0;
                ElemCnt <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (Key) begin
                            state   <= PRESS;
                            cnt     <= CNT_ONE;
                            ElemCnt <= 3'd0;
                        end
                    end
                    PRESS: begin
                        if (Key) begin
                            cnt <= cnt_next;
                        end else begin
                            state <= GAP;
                            cnt   <= CNT_ONE;
                            if (cnt <= DOT_LIM) Dot <= 1'b1;
                            else                Dash <= 1'b1;
                            ElemCnt <= elem_inc(ElemCnt);
                        end
                    end
                    GAP: begin
                        // A press on a threshold cycle wins over the gap pulse
                        if (Key) begin
                            state <= PRESS;
                            cnt   <= CNT_ONE;
                        end else if (cnt_next == TO_LIM) begin
                            Timeout <= 1'b1;
                            state   <= IDLE;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt_next;
                            if (cnt_next == LG_LIM) begin
                                LetterEnd <= 1'b1;
                                ElemCnt   <= 3'd0;
                            end
                            if (cnt_next == WG_LIM) WordEnd <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_interval_timer.sv
// Directed bench for morse_interval_timer: default thresholds plus a 4-bit
// counter instance exercising counter saturation.
module tb_morse_interval_timer;

    logic clk = 1'b0;
    logic rst, en, key;

    logic       dot, dash, letter_end, word_end, timeout, busy;
    logic [2:0] elem_cnt;
    logic       dot4, dash4, letter_end4, word_end4, timeout4, busy4;
    logic [2:0] elem_cnt4;

    int n_cmp = 0;
    int n_bad = 0;
    int n_dot = 0, n_dash = 0, n_le = 0, n_we = 0, n_to = 0;
    int n_dot4 = 0, n_dash4 = 0;

    always #5 clk = ~clk;

    morse_interval_timer dut (
        .Clk(clk), .Reset(rst), .Enable(en), .Key(key),
        .Dot(dot), .Dash(dash), .LetterEnd(letter_end), .WordEnd(word_end),
        .Timeout(timeout), .ElemCnt(elem_cnt), .Busy(busy)
    );

    morse_interval_timer #(
        .CNT_W(4), .DOT_MAX(3), .LETTER_GAP(6), .WORD_GAP(10), .TIMEOUT(14)
    ) dut4 (
        .Clk(clk), .Reset(rst), .Enable(en), .Key(key),
        .Dot(dot4), .Dash(dash4), .LetterEnd(letter_end4), .WordEnd(word_end4),
        .Timeout(timeout4), .ElemCnt(elem_cnt4), .Busy(busy4)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int all_out();
        return int'({dot, dash, letter_end, word_end, timeout, elem_cnt, busy});
    endfunction

    task automatic cyc(input logic k);
        key = k;
        @(posedge clk);
        #1;
        n_dot   += int'(dot);
        n_dash  += int'(dash);
        n_le    += int'(letter_end);
        n_we    += int'(word_end);
        n_to    += int'(timeout);
        n_dot4  += int'(dot4);
        n_dash4 += int'(dash4);
    endtask

    task automatic clear_counts();
        n_dot = 0; n_dash = 0; n_le = 0; n_we = 0; n_to = 0;
        n_dot4 = 0; n_dash4 = 0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; key = 1'b0;
        cyc(0); cyc(0);
        check("reset_outputs", all_out(), 0);
        check("reset_outputs_w4", int'({dot4, dash4, elem_cnt4, busy4}), 0);
        rst = 1'b0;
        cyc(0);
        check("idle_busy", int'(busy), 0);

        // Dot of 3 cycles, then dash of 4 cycles
        clear_counts();
        for (int i = 0; i < 3; i++) cyc(1);
        check("press_busy", int'(busy), 1);
        check("press_no_dot_yet", int'(dot), 0);
        cyc(0);
        check("dot_pulse", int'(dot), 1);
        check("dot_not_dash", int'(dash), 0);
        check("dot_elem", int'(elem_cnt), 1);
        for (int i = 0; i < 4; i++) cyc(1);
        check("dot_one_cycle", n_dot, 1);
        cyc(0);
        check("dash_pulse", int'(dash), 1);
        check("dash_not_dot", int'(dot), 0);
        check("dash_elem", int'(elem_cnt), 2);

        // Release runs through letter gap, word gap and timeout
        clear_counts();
        for (int i = 2; i <= 31; i++) begin
            cyc(0);
            check($sformatf("gap_le_%0d", i), int'(letter_end), int'(i == 6));
            check($sformatf("gap_we_%0d", i), int'(word_end), int'(i == 14));
            check($sformatf("gap_to_%0d", i), int'(timeout), int'(i == 30));
            check($sformatf("gap_busy_%0d", i), int'(busy), int'(i < 30));
            check($sformatf("gap_elem_%0d", i), int'(elem_cnt), (i < 6) ? 2 : 0);
        end
        check("gap_le_count", n_le, 1);
        check("gap_we_count", n_we, 1);
        check("gap_to_count", n_to, 1);

        // Re-press on the letter-gap threshold cycle: no LetterEnd
        clear_counts();
        cyc(1); cyc(0);
        check("repress_first_elem", int'(elem_cnt), 1);
        for (int i = 0; i < 4; i++) cyc(0);
        cyc(1); cyc(1);
        cyc(0);
        check("repress_dot", int'(dot), 1);
        check("repress_elem", int'(elem_cnt), 2);
        check("repress_no_le", n_le, 0);

        // Letter ends, then eight dots with 2-cycle gaps saturate ElemCnt
        for (int i = 0; i < 5; i++) cyc(0);
        check("letter_end_before_dots", int'(letter_end), 1);
        check("letter_elem_clear", int'(elem_cnt), 0);
        clear_counts();
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            cyc(0);
            check($sformatf("sat_elem_%0d", k), int'(elem_cnt), (k > 7) ? 7 : k);
            cyc(0);
        end
        check("sat_dot_count", n_dot, 8);
        check("sat_no_le", n_le, 0);
        check("sat_busy", int'(busy), 1);

        // Enable dropped mid-press aborts without classifying
        clear_counts();
        for (int i = 0; i < 3; i++) cyc(1);
        en = 1'b0;
        cyc(1);
        check("enable_off_outputs", all_out(), 0);
        en = 1'b1;
        cyc(0);
        check("enable_after_outputs", all_out(), 0);
        cyc(0);
        check("enable_no_elem", n_dot + n_dash, 0);

        // Asynchronous reset mid-gap
        cyc(1); cyc(1); cyc(0);
        check("pre_reset_dot", int'(dot), 1);
        cyc(0); cyc(0); cyc(0);
        clear_counts();
        rst = 1'b1;
        #1;
        check("async_reset_outputs", all_out(), 0);
        cyc(0);
        check("reset_hold_outputs", all_out(), 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) cyc(0);
        check("reset_no_le", n_le, 0);
        check("reset_no_pulses", n_dot + n_dash + n_we + n_to, 0);
        check("reset_busy", int'(busy), 0);

        // 4-bit counter: long presses saturate and remain dashes
        rst = 1'b1;
        cyc(0);
        rst = 1'b0;
        clear_counts();
        for (int i = 0; i < 40; i++) cyc(1);
        cyc(0);
        check("w4_dash40", int'(dash4), 1);
        check("w4_dot40", int'(dot4), 0);
        for (int i = 0; i < 34; i++) cyc(1);
        cyc(0);
        check("w4_dash34", int'(dash4), 1);
        check("w4_dot34", int'(dot4), 0);
        cyc(0);
        check("w4_dash_count", n_dash4, 2);
        check("w4_dot_count", n_dot4, 0);
        check("w4_elem", int'(elem_cnt4), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
